// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state codes, PC source select
// codes and the default datapath width.
package instr_fetch_unit_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_ERR  = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        PCSRC_INC  = 2'b00,
        PCSRC_ALU  = 2'b01,
        PCSRC_REGA = 2'b10,
        PCSRC_HOLD = 2'b11
    } pc_src_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_mux.sv
// Next-PC selector: picks the sequential, branch or jump-register target.
// Shared by the immediate PC load and the pending-redirect capture.
module instr_fetch_unit_pc_next_mux
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_W = instr_fetch_unit_pkg::DATA_W,
    parameter int PC_INC = 2
) (
    input  logic [1:0]        pc_source,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] pc_next
);

    // Select the candidate PC; HOLD returns the current PC unchanged.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves pc_next
        // unassigned, which would otherwise infer a latch.
        pc_next = pc;
        case (pc_src_t'(pc_source))
            PCSRC_INC:  pc_next = pc + DATA_W'(PC_INC);
            PCSRC_ALU:  pc_next = alu_out;
            PCSRC_REGA: pc_next = reg_a;
            default:    pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns PC and IR, runs the req/ack handshake to
// instruction memory with a timeout, and buffers PC redirects that arrive
// while a fetch is in flight.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                DATA_W   = instr_fetch_unit_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 2,
    parameter int                MAX_WAIT = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FetchStart,
    input  logic              PCWrite,
    input  logic [1:0]        PCSource,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] Reg_A,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              MemReq,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] IR,
    output logic [3:0]        IR15_12,
    output logic [7:0]        IR7_0,
    output logic [3:0]        IR3_0,
    output logic [DATA_W-1:0] PC,
    output logic              IRValid,
    output logic              Busy,
    output logic              FetchErr
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t      state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] pc_q, ir_q, pend_pc, pc_sel;
    logic              pend_valid;
    logic              mem_req_q, busy_q, fetch_err_q, ir_valid_q;
    logic              redirect, fetch_go, fetch_done;

    // A HOLD write is a no-op: it neither moves PC nor records a redirect.
    assign redirect = PCWrite && (pc_src_t'(PCSource) != PCSRC_HOLD);

    instr_fetch_unit_pc_next_mux #(
        .DATA_W (DATA_W),
        .PC_INC (PC_INC)
    ) u_pc_next_mux (
        .pc_source (PCSource),
        .pc        (pc_q),
        .alu_out   (ALUOut),
        .reg_a     (Reg_A),
        .pc_next   (pc_sel)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (Reset) state <= FETCH_IDLE;
        else       state <= state_next;
    end

    // Next-state decode; an ack on the last allowed wait cycle still wins.
    always_comb begin
        state_next = state;
        fetch_go   = 1'b0;
        fetch_done = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (FetchStart) begin
                    fetch_go   = 1'b1;
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (MemAck) begin
                    fetch_done = 1'b1;
                    state_next = FETCH_IDLE;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    state_next = FETCH_ERR;
                end
            end
            FETCH_ERR: state_next = FETCH_ERR;
            default:   state_next = FETCH_IDLE;
        endcase
    end

    // PC, IR, pending redirect, wait counter and registered status outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            pend_pc     <= '0;
            pend_valid  <= 1'b0;
            wait_cnt    <= '0;
            ir_valid_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            mem_req_q   <= (state_next == FETCH_REQ);
            busy_q      <= (state_next == FETCH_REQ);
            fetch_err_q <= (state_next == FETCH_ERR);

            // In IDLE a write lands now, so a same-cycle fetch uses the new PC.
            if (state == FETCH_IDLE && redirect) pc_q <= pc_sel;

            if (fetch_go) begin
                wait_cnt   <= '0;
                ir_valid_q <= 1'b0;
                pend_valid <= 1'b0;
            end

            // In REQ, MemAddr must stay put: park the target until completion.
            if (state == FETCH_REQ) begin
                if (redirect) begin
                    pend_pc    <= pc_sel;
                    pend_valid <= 1'b1;
                end
                if (!MemAck) wait_cnt <= wait_cnt + 1'b1;
            end

            if (fetch_done) begin
                ir_q       <= MemRData;
                ir_valid_q <= 1'b1;
                pend_valid <= 1'b0;
                if (redirect)        pc_q <= pc_sel;
                else if (pend_valid) pc_q <= pend_pc;
                else                 pc_q <= pc_q + DATA_W'(PC_INC);
            end
        end
    end

    assign MemReq   = mem_req_q;
    assign Busy     = busy_q;
    assign FetchErr = fetch_err_q;
    assign IRValid  = ir_valid_q;
    assign PC       = pc_q;
    assign MemAddr  = pc_q;
    assign IR       = ir_q;
    assign IR15_12  = ir_q[DATA_W-1 -: 4];
    assign IR7_0    = ir_q[7:0];
    assign IR3_0    = ir_q[3:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a directed vector table, hand
// sequences for timeout/wrap/reset corners, and randomized traffic checked
// against a transaction-level reference model.
module tb_instr_fetch_unit;

    localparam int MAX_WAIT = 8;

    logic        CLK = 1'b0;
    logic        Reset, FetchStart, PCWrite, MemAck;
    logic [1:0]  PCSource;
    logic [15:0] ALUOut, Reg_A, MemRData;
    logic        MemReq, IRValid, Busy, FetchErr;
    logic [15:0] MemAddr, IR, PC;
    logic [3:0]  IR15_12, IR3_0;
    logic [7:0]  IR7_0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .Reset(Reset), .FetchStart(FetchStart), .PCWrite(PCWrite),
        .PCSource(PCSource), .ALUOut(ALUOut), .Reg_A(Reg_A), .MemAck(MemAck),
        .MemRData(MemRData), .MemReq(MemReq), .MemAddr(MemAddr), .IR(IR),
        .IR15_12(IR15_12), .IR7_0(IR7_0), .IR3_0(IR3_0), .PC(PC),
        .IRValid(IRValid), .Busy(Busy), .FetchErr(FetchErr)
    );

    // Reference model: a fetch is "in flight" or not, the unit is "dead"
    // after a timeout, and a redirect seen mid-fetch is an optional target.
    logic [15:0] m_pc, m_ir, m_pend;
    logic        m_valid, m_inflight, m_dead, m_has_pend;
    int          m_waited;

    function automatic logic [15:0] target(input logic [1:0] src, input logic [15:0] pc,
                                           input logic [15:0] alu, input logic [15:0] rega);
        case (src)
            2'd0:    return pc + 16'd2;
            2'd1:    return alu;
            2'd2:    return rega;
            default: return pc;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_update();
        if (Reset) begin
            m_pc = 16'h0000; m_ir = 16'h0000; m_valid = 0;
            m_inflight = 0; m_dead = 0; m_has_pend = 0; m_waited = 0;
        end else if (m_dead) begin
            // stuck until reset
        end else if (!m_inflight) begin
            if (PCWrite && PCSource != 2'd3) m_pc = target(PCSource, m_pc, ALUOut, Reg_A);
            if (FetchStart) begin
                m_inflight = 1; m_waited = 0; m_valid = 0; m_has_pend = 0;
            end
        end else begin
            if (PCWrite && PCSource != 2'd3) begin
                m_pend = target(PCSource, m_pc, ALUOut, Reg_A);
                m_has_pend = 1;
            end
            if (MemAck) begin
                m_ir = MemRData;
                m_pc = m_has_pend ? m_pend : m_pc + 16'd2;
                m_valid = 1; m_inflight = 0; m_has_pend = 0;
            end else begin
                m_waited++;
                if (m_waited == MAX_WAIT) begin
                    m_dead = 1; m_inflight = 0;
                end
            end
        end
    endtask

    task automatic model_compare();
        check("mem_req",   {31'd0, MemReq},   {31'd0, m_inflight});
        check("busy",      {31'd0, Busy},     {31'd0, m_inflight});
        check("fetch_err", {31'd0, FetchErr}, {31'd0, m_dead});
        check("ir_valid",  {31'd0, IRValid},  {31'd0, m_valid});
        check("pc",        {16'd0, PC},       {16'd0, m_pc});
        check("mem_addr",  {16'd0, MemAddr},  {16'd0, m_pc});
        check("ir",        {16'd0, IR},       {16'd0, m_ir});
        check("ir_fields", {16'd0, IR15_12, IR7_0, IR3_0},
              {16'd0, m_ir[15:12], m_ir[7:0], m_ir[3:0]});
    endtask

    // One clock: advance the model on this cycle's inputs, then sample away from the edge.
    task automatic step();
        model_update();
        @(posedge CLK);
        #1;
        model_compare();
    endtask

    task automatic drive(input logic rst, input logic fs, input logic pw, input logic [1:0] src,
                         input logic [15:0] alu, input logic [15:0] rega,
                         input logic ack, input logic [15:0] rdata);
        Reset = rst; FetchStart = fs; PCWrite = pw; PCSource = src;
        ALUOut = alu; Reg_A = rega; MemAck = ack; MemRData = rdata;
    endtask

    typedef struct {
        logic        rst, fs, pw;
        logic [1:0]  src;
        logic [15:0] alu, rega;
        logic        ack;
        logic [15:0] rdata;
        logic        e_req, e_busy, e_err, e_valid;
        logic [15:0] e_pc, e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic fs, input logic pw, input logic [1:0] src,
                                input logic [15:0] alu, input logic [15:0] rega, input logic ack,
                                input logic [15:0] rdata, input logic e_req, input logic e_busy,
                                input logic e_err, input logic e_valid, input logic [15:0] e_pc,
                                input logic [15:0] e_ir);
        vec_t v;
        v.rst = rst; v.fs = fs; v.pw = pw; v.src = src; v.alu = alu; v.rega = rega;
        v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_busy = e_busy; v.e_err = e_err;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_ir = e_ir;
        return v;
    endfunction

    initial begin
        drive(1, 0, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);

        // Directed table: inputs for one cycle, expected outputs after the edge.
        tbl.push_back(mk(1,0,0,2'd0,16'h0,16'h0,0,16'h0,     0,0,0,0,16'h0000,16'h0000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,0,16'h0, 0,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,0,16'h0,     1,1,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,0,16'h0,     1,1,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,1,16'h8107,  0,0,0,1,16'h0002,16'h8107));
        tbl.push_back(mk(0,0,1,2'd1,16'h0040,16'h0,0,16'h0,  0,0,0,1,16'h0040,16'h8107));
        tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,0,16'h0,     1,1,0,0,16'h0040,16'h8107));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,1,16'h1111,  0,0,0,1,16'h0042,16'h1111));
        tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,0,16'h0,     1,1,0,0,16'h0042,16'h1111));
        tbl.push_back(mk(0,0,1,2'd2,16'h0,16'h1234,0,16'h0,  1,1,0,0,16'h0042,16'h1111));
        tbl.push_back(mk(0,0,1,2'd3,16'h0,16'h0,0,16'h0,     1,1,0,0,16'h0042,16'h1111));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,1,16'h2222,  0,0,0,1,16'h1234,16'h2222));
        tbl.push_back(mk(0,1,1,2'd1,16'h0100,16'h0,0,16'h0,  1,1,0,0,16'h0100,16'h2222));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,1,16'h3333,  0,0,0,1,16'h0102,16'h3333));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,1,16'h9999,  0,0,0,1,16'h0102,16'h3333));
        tbl.push_back(mk(0,0,1,2'd0,16'h0,16'h0,0,16'h0,     0,0,0,1,16'h0104,16'h3333));
        tbl.push_back(mk(0,0,1,2'd3,16'h0,16'h0,0,16'h0,     0,0,0,1,16'h0104,16'h3333));
        tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,1,16'h5555,  1,1,0,0,16'h0104,16'h3333));
        tbl.push_back(mk(0,1,0,2'd0,16'h0,16'h0,0,16'h0,     1,1,0,0,16'h0104,16'h3333));
        tbl.push_back(mk(0,0,0,2'd0,16'h0,16'h0,1,16'h4444,  0,0,0,1,16'h0106,16'h4444));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fs, tbl[i].pw, tbl[i].src, tbl[i].alu, tbl[i].rega,
                  tbl[i].ack, tbl[i].rdata);
            step();
            check($sformatf("vec%0d_req", i), {31'd0, MemReq}, {31'd0, tbl[i].e_req});
            check($sformatf("vec%0d_busy", i), {31'd0, Busy}, {31'd0, tbl[i].e_busy});
            check($sformatf("vec%0d_err", i), {31'd0, FetchErr}, {31'd0, tbl[i].e_err});
            check($sformatf("vec%0d_valid", i), {31'd0, IRValid}, {31'd0, tbl[i].e_valid});
            check($sformatf("vec%0d_pc", i), {16'd0, PC}, {16'd0, tbl[i].e_pc});
            check($sformatf("vec%0d_addr", i), {16'd0, MemAddr}, {16'd0, tbl[i].e_pc});
            check($sformatf("vec%0d_ir", i), {16'd0, IR}, {16'd0, tbl[i].e_ir});
            check($sformatf("vec%0d_op", i), {28'd0, IR15_12}, {28'd0, tbl[i].e_ir[15:12]});
        end

        // Timeout: MemReq high for exactly MAX_WAIT cycles, then sticky error.
        drive(0, 1, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check("to_req_first", {31'd0, MemReq}, 32'd1);
        for (int i = 1; i < MAX_WAIT; i++) begin
            drive(0, 0, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
            step();
            check($sformatf("to_req_c%0d", i + 1), {31'd0, MemReq, FetchErr}, 32'b10);
        end
        drive(0, 0, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check("to_err_entry", {29'd0, MemReq, Busy, FetchErr}, 32'b001);
        check("to_pc_held", {16'd0, PC}, 32'h0106);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 2'd1, 16'hBEEF, 16'h0, 1, 16'hABCD);
            step();
            check("err_sticky", {30'd0, MemReq, FetchErr}, 32'b01);
            check("err_hold", {PC, IR}, {16'h0106, 16'h4444});
        end
        drive(1, 0, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check("err_reset", {15'd0, FetchErr, PC}, 32'h0);

        // Ack on the MAX_WAIT-th request cycle still counts as success.
        drive(0, 1, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
        step();
        for (int i = 1; i < MAX_WAIT; i++) begin
            drive(0, 0, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
            step();
        end
        drive(0, 0, 0, 2'd0, 16'h0, 16'h0, 1, 16'h7777);
        step();
        check("late_ack_ok", {14'd0, FetchErr, IRValid, IR}, {14'd0, 2'b01, 16'h7777});
        check("late_ack_pc", {16'd0, PC}, 32'h0002);

        // PC wrap at the top of the address space.
        drive(0, 1, 1, 2'd1, 16'hFFFE, 16'h0, 0, 16'h0);
        step();
        check("wrap_addr", {16'd0, MemAddr}, 32'hFFFE);
        drive(0, 0, 0, 2'd0, 16'h0, 16'h0, 1, 16'h0A0A);
        step();
        check("wrap_pc", {PC, IR}, {16'h0000, 16'h0A0A});

        // Reset mid-fetch aborts it and ignores the coincident ack.
        drive(0, 1, 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
        step();
        drive(1, 0, 0, 2'd0, 16'h0, 16'h0, 1, 16'h5A5A);
        step();
        check("rst_mid_req", {13'd0, MemReq, IRValid, Busy, PC}, 32'h0);
        check("rst_mid_ir", {16'd0, IR}, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                  2'($urandom_range(3)), 16'($urandom), 16'($urandom),
                  ($urandom_range(2) == 0), 16'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
